// File: rtl/tiny16_timer_irq.sv
`default_nettype none
// ============================================================================
// tiny16_timer_irq : prescaled down-counter timer with irq, wake and LED for Tiny16
// Revision 1.0
// ============================================================================
module tiny16_timer_irq #(
  parameter int COUNTER_BITS = 8,
  parameter int TIMER_BIT    = 7
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        nhlt,
  input  logic        nwfi,
  input  logic        iack,
  output logic        irq,
  output logic        wake,
  output logic        led
);

  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_RELOAD = 2'd1;
  localparam logic [1:0] C_ADDR_COUNT  = 2'd2;
  localparam logic [1:0] C_ADDR_STATUS = 2'd3;

  logic [COUNTER_BITS-1:0] prescaler_q, prescaler_d;
  logic [2:0]              ctrl_q, ctrl_d;
  logic [15:0]             reload_q, reload_d;
  logic [15:0]             count_q, count_d;
  logic                    pending_q, pending_d;
  logic [7:0]              overrun_q, overrun_d;
  logic                    wake_q, wake_d;
  logic                    led_q, led_d;

  logic w_tick;
  logic w_ctrl_wr;
  logic w_reload_wr;
  logic w_count_wr;
  logic w_status_wr;
  logic w_event;
  logic w_enable;
  logic w_irq_en;
  logic w_autoreload;

  assign w_enable     = ctrl_q[0];
  assign w_irq_en     = ctrl_q[1];
  assign w_autoreload = ctrl_q[2];

  assign w_ctrl_wr   = we && (addr == C_ADDR_CTRL);
  assign w_reload_wr = we && (addr == C_ADDR_RELOAD);
  assign w_count_wr  = we && (addr == C_ADDR_COUNT);
  assign w_status_wr = we && (addr == C_ADDR_STATUS);

  assign w_tick  = nhlt && (&prescaler_q[TIMER_BIT:0]);
  // A COUNT write pre-empts the tick, so it also suppresses the event.
  assign w_event = w_tick && w_enable && (count_q == 16'd0) && !w_count_wr;

  always_comb begin
    prescaler_d = prescaler_q;
    ctrl_d      = ctrl_q;
    reload_d    = reload_q;
    count_d     = count_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    wake_d      = !nwfi && pending_q;
    led_d       = led_q ^ w_event;

    if (nhlt) begin
      prescaler_d = prescaler_q + COUNTER_BITS'(1);
    end

    if (w_tick && w_enable) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        count_d = w_autoreload ? reload_q : 16'd0;
        if (!w_autoreload) begin
          ctrl_d[0] = 1'b0;
        end
      end
    end
    if (w_count_wr) begin
      count_d = wdata;
    end
    if (w_ctrl_wr) begin
      ctrl_d = wdata[2:0];
    end
    if (w_reload_wr) begin
      reload_d = wdata;
    end

    // An ack landing with a new event leaves pending set and is not an overrun.
    if (iack) begin
      pending_d = 1'b0;
    end
    if (w_event && w_irq_en) begin
      pending_d = 1'b1;
      if (pending_q && !iack && (overrun_q != 8'hFF)) begin
        overrun_d = overrun_q + 8'd1;
      end
    end
    if (w_status_wr) begin
      overrun_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prescaler_q <= '0;
      ctrl_q      <= 3'd0;
      reload_q    <= 16'd0;
      count_q     <= 16'd0;
      pending_q   <= 1'b0;
      overrun_q   <= 8'd0;
      wake_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      ctrl_q      <= ctrl_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      wake_q      <= wake_d;
      led_q       <= led_d;
    end
  end

  always_comb begin
    rdata = 16'd0;
    case (addr)
      C_ADDR_CTRL:   rdata = {13'd0, ctrl_q};
      C_ADDR_RELOAD: rdata = reload_q;
      C_ADDR_COUNT:  rdata = count_q;
      C_ADDR_STATUS: rdata = {overrun_q, 7'd0, pending_q};
      default:       rdata = 16'd0;
    endcase
  end

  assign irq  = pending_q;
  assign wake = wake_q;
  assign led  = led_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny16_timer_irq.sv
`default_nettype none
// ============================================================================
// tb_tiny16_timer_irq : scoreboard bench for tiny16_timer_irq (tick every 8 clk)
// Revision 1.0
// ============================================================================
module tb_tiny16_timer_irq;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata;
  logic        nhlt = 1'b1;
  logic        nwfi = 1'b1;
  logic        iack = 1'b0;
  logic        irq;
  logic        wake;
  logic        led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_ev = 0;
  int last_wr_cyc = 0;
  logic [15:0] exp_q[$];

  tiny16_timer_irq #(
    .COUNTER_BITS(8),
    .TIMER_BIT   (2)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .nhlt  (nhlt),
    .nwfi  (nwfi),
    .iack  (iack),
    .irq   (irq),
    .wake  (wake),
    .led   (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
  endtask

  task automatic wait_event(input int budget, output bit ok);
    logic l0;
    l0 = led;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (led !== l0) begin
        ok = 1'b1;
        last_ev = cyc;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL event_timeout: no led toggle within %0d clk", budget);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d, e;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL reset_irq: got %0d expected %0d", irq, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, wake} !== e) begin failures++; $display("FAIL reset_wake: got %0d expected %0d", wake, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL reset_led: got %0d expected %0d", led, e); end
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(16'h0000);
      rd(2'(a), d);
      e = exp_q.pop_front(); checks++;
      if (d !== e) begin failures++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, e); end
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_periodic();
    logic [15:0] d, e;
    bit ok;
    int prev;
    wr(2'd1, 16'd3);
    wr(2'd0, 16'h0007);
    exp_q.push_back(16'd0);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL periodic_irq_pre: got %0d expected %0d", irq, e); end
    exp_q.push_back(16'd1); exp_q.push_back(16'd1);
    wait_event(40, ok);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL periodic_led1: got %0d expected %0d", led, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL periodic_irq1: got %0d expected %0d", irq, e); end
    for (int k = 0; k < 2; k++) begin
      prev = last_ev;
      exp_q.push_back(16'(k[0] ? 1 : 0));
      exp_q.push_back(16'd32);
      wait_event(40, ok);
      e = exp_q.pop_front(); checks++;
      if ({15'd0, led} !== e) begin failures++; $display("FAIL periodic_led%0d: got %0d expected %0d", k + 2, led, e); end
      e = exp_q.pop_front(); checks++;
      if (16'(last_ev - prev) !== e) begin failures++; $display("FAIL periodic_gap%0d: got %0d expected %0d", k + 2, last_ev - prev, e); end
    end
    exp_q.push_back(16'h0201);
    rd(2'd3, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL overrun3_status: got %h expected %h", d, e); end
  endtask

  task automatic test_ack();
    logic [15:0] d, e;
    logic l0;
    bit ok;
    int ev;
    wr(2'd3, 16'hFFFF);
    exp_q.push_back(16'h0001);
    rd(2'd3, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL status_clear: got %h expected %h", d, e); end
    exp_q.push_back(16'd0);
    ack_pulse();
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL ack_irq: got %0d expected %0d", irq, e); end
    exp_q.push_back(16'd1);
    wait_event(40, ok);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL ack_reraise: got %0d expected %0d", irq, e); end
    ev = last_ev;
    while (cyc != ev + 31) @(negedge clk);
    l0 = led;
    iack = 1'b1;
    exp_q.push_back(16'(!l0)); exp_q.push_back(16'd1); exp_q.push_back(16'h0001);
    @(negedge clk);
    iack = 1'b0;
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL coinc_event: got led %0d expected %0d", led, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL coinc_irq: got %0d expected %0d", irq, e); end
    rd(2'd3, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL coinc_status: got %h expected %h", d, e); end
  endtask

  task automatic test_saturate();
    logic [15:0] d, e;
    bit ok;
    int n;
    wr(2'd1, 16'd0);
    exp_q.push_back(16'd300);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      wait_event(40, ok);
      if (!ok) break;
      n++;
    end
    e = exp_q.pop_front(); checks++;
    if (16'(n) !== e) begin failures++; $display("FAIL sat_events: got %0d expected %0d", n, e); end
    exp_q.push_back(16'hFF01);
    rd(2'd3, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL sat_status: got %h expected %h", d, e); end
    wr(2'd3, 16'h0000);
    exp_q.push_back(16'h0001);
    rd(2'd3, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL sat_clear: got %h expected %h", d, e); end
  endtask

  task automatic test_oneshot();
    logic [15:0] d, e;
    logic l0;
    bit ok, toggled;
    int el;
    wr(2'd0, 16'h0000);
    ack_pulse();
    wr(2'd2, 16'd2);
    wr(2'd0, 16'h0003);
    l0 = led;
    exp_q.push_back(16'(!l0)); exp_q.push_back(16'd1); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0000); exp_q.push_back(16'd0);
    wait_event(40, ok);
    el = last_ev - last_wr_cyc;
    checks++;
    if (el < 17 || el > 24) begin failures++; $display("FAIL oneshot_latency: got %0d clk expected 17..24", el); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL oneshot_led: got %0d expected %0d", led, e); end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, irq} !== e) begin failures++; $display("FAIL oneshot_irq: got %0d expected %0d", irq, e); end
    rd(2'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL oneshot_ctrl: got %h expected %h", d, e); end
    rd(2'd2, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL oneshot_count: got %h expected %h", d, e); end
    l0 = led;
    toggled = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (led !== l0) toggled = 1'b1;
    end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, toggled} !== e) begin failures++; $display("FAIL oneshot_quiet: got %0d extra toggles expected %0d", toggled, e); end
  endtask

  task automatic test_core_status();
    logic [15:0] d, e, v;
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, wake} !== e) begin failures++; $display("FAIL wake_idle: got %0d expected %0d", wake, e); end
    nwfi = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, wake} !== e) begin failures++; $display("FAIL wake_set: got %0d expected %0d", wake, e); end
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    e = exp_q.pop_front(); checks++;
    if ({15'd0, wake} !== e) begin failures++; $display("FAIL wake_hold: got %0d expected %0d", wake, e); end
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, wake} !== e) begin failures++; $display("FAIL wake_drop: got %0d expected %0d", wake, e); end
    nwfi = 1'b1;
    wr(2'd2, 16'h0100);
    wr(2'd0, 16'h0001);
    repeat (10) @(negedge clk);
    nhlt = 1'b0;
    rd(2'd2, v);
    exp_q.push_back(v);
    repeat (50) @(negedge clk);
    rd(2'd2, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL halt_freeze: got %h expected %h", d, e); end
    nhlt = 1'b1;
    repeat (20) @(negedge clk);
    rd(2'd2, d);
    checks++;
    if (d !== v - 16'd2 && d !== v - 16'd3) begin
      failures++; $display("FAIL halt_resume: got %h expected %h or %h", d, v - 16'd2, v - 16'd3);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d, e;
    bit ok, toggled;
    wr(2'd1, 16'h0040);
    wr(2'd0, 16'h0005);
    wr(2'd2, 16'h0000);
    wait_event(16, ok);
    if (led === 1'b0) begin
      wr(2'd2, 16'h0000);
      wait_event(16, ok);
    end
    exp_q.push_back(16'd1);
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL arst_pre_led: got %0d expected %0d", led, e); end
    repeat (5) @(negedge clk);
    exp_q.push_back(16'd0); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'd0);
    #1 nreset = 1'b0;
    #1;
    e = exp_q.pop_front(); checks++;
    if ({15'd0, led} !== e) begin failures++; $display("FAIL arst_led: got %0d expected %0d", led, e); end
    rd(2'd2, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL arst_count: got %h expected %h", d, e); end
    rd(2'd0, d);
    e = exp_q.pop_front(); checks++;
    if (d !== e) begin failures++; $display("FAIL arst_ctrl: got %h expected %h", d, e); end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    toggled = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (led !== 1'b0) toggled = 1'b1;
    end
    e = exp_q.pop_front(); checks++;
    if ({15'd0, toggled} !== e) begin failures++; $display("FAIL arst_no_event: got %0d expected %0d", toggled, e); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_ack();
    test_saturate();
    test_oneshot();
    test_core_status();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
